// File: rtl/usrt_tx.sv
// usrt_tx: USRT serial transmitter.
// Builds the frame {stop, parity, data[7:0], start} and shifts it out LSB-first.
// Each bit lasts CLKS_PER_BIT cycles. The parity slot is present only in even
// or odd mode.
// Optional feature macro USRT_SCLK_EN adds the o_SClk bit-clock output. Its
// rising edge falls in the middle of each bit, and it is held high when idle.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, ready for a new byte
// S_START  | start bit (line low)
// S_DATA   | data bits 0..7, LSB first
// S_PARITY | parity bit (even/odd modes only)
// S_STOP   | stop bit (line high), o_TxDone raised on exit
module usrt_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_Pclk,
  input  logic       i_Rst_n,
  input  logic       i_TxStart,
  input  logic [7:0] i_Data,
  input  logic [1:0] i_Parity,
  output logic       o_Serial,
  output logic       o_TxReady,
  output logic       o_TxBusy,
  output logic       o_TxDone
`ifdef USRT_SCLK_EN
  ,
  output logic       o_SClk
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             bit_done;

  // The down-counter reaching zero marks the last cycle of the current bit.
  assign bit_done = (cnt_q == '0);

  // State register.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: every bit advances on the terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_TxStart) state_d = S_START;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA:   if (bit_done && (bit_idx_q == 3'd7)) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: byte and parity capture on accept, bit timer, and data shifting.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    if (state_q == S_IDLE) begin
      if (i_TxStart) begin
        cnt_d     = CNT_MAX;
        bit_idx_d = 3'd0;
        shift_d   = i_Data;
        par_en_d  = (i_Parity == 2'b01) || (i_Parity == 2'b10);
        par_bit_d = (i_Parity == 2'b10) ? ~^i_Data : ^i_Data;
      end
    end else if (!bit_done) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = (state_q == S_STOP) ? '0 : CNT_MAX;
      if (state_q == S_DATA) begin
        bit_idx_d = bit_idx_q + 3'd1;
        shift_d   = {1'b0, shift_q[7:1]};
      end
    end
  end

  // Output logic: the line level follows the upcoming state, so o_Serial
  // changes on the same edge as the state and comes straight from a flop.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_bit_q;
      default:  serial_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && bit_done;
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  assign o_Serial  = serial_q;
  assign o_TxDone  = done_q;
  assign o_TxReady = (state_q == S_IDLE);
  assign o_TxBusy  = (state_q != S_IDLE);

`ifdef USRT_SCLK_EN
  // Counter values at or above this are the low half of a bit.
  localparam logic [CNT_W-1:0] SCLK_LOW_MIN = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic sclk_q, sclk_d;

  // Bit clock: low for the first half of each bit, high otherwise and when idle.
  always_comb begin
    sclk_d = 1'b1;
    if ((state_d != S_IDLE) && (cnt_d >= SCLK_LOW_MIN)) sclk_d = 1'b0;
  end

  // Bit clock register.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) sclk_q <= 1'b1;
    else          sclk_q <= sclk_d;
  end

  assign o_SClk = sclk_q;
`endif

endmodule

// File: tb/tb_usrt_tx.sv
// Testbench for usrt_tx with CLKS_PER_BIT=4.
// Expected frames are queued when a byte is offered. A line monitor pops each
// entry when a frame begins and checks it by sampling every bit at mid-bit.
`timescale 1ns/1ps
module tb_usrt_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] par = 2'b00;
  logic       serial, ready, busy, done;
`ifdef USRT_SCLK_EN
  logic       sclk;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [10:0] frame;
    int          nbits;
    int          start_cyc;
    bit          b2b;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_on = 1'b0;
  bit   mon_busy = 1'b0;
  bit   busy_prev = 1'b0;
  int   last_done_cyc = -100;

  usrt_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Pclk    (clk),
    .i_Rst_n   (rst_n),
    .i_TxStart (tx_start),
    .i_Data    (data),
    .i_Parity  (par),
    .o_Serial  (serial),
    .o_TxReady (ready),
    .o_TxBusy  (busy),
    .o_TxDone  (done)
`ifdef USRT_SCLK_EN
    ,
    .o_SClk    (sclk)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference frame built straight from the frame definition.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] m);
    exp_t e;
    logic p;
    e.start_cyc = -1;
    e.b2b       = 1'b0;
    if (m == 2'b01 || m == 2'b10) begin
      p       = (m == 2'b10) ? ~^d : ^d;
      e.nbits = 11;
      e.frame = {1'b1, p, d, 1'b0};
    end else begin
      e.nbits = 10;
      e.frame = {1'b0, 1'b1, d, 1'b0};
    end
    return e;
  endfunction

  // Offer one byte for a single cycle; called on a falling edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic [10:0] frame, input int nbits);
    exp_t e;
    int n = 0;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 500), 1);
    tx_start    = 1'b1;
    data        = d;
    par         = m;
    e.frame     = frame;
    e.nbits     = nbits;
    e.start_cyc = cyc + 1;
    e.b2b       = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    tx_start = 1'b0;
    data     = 8'($urandom);
    par      = 2'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 1000), 1);
  endtask

  // Line monitor / scoreboard consumer.
  initial begin
    exp_t        e;
    logic [10:0] cap;
    bit          hs_bad;
    bit          sclk_bad;
    int          start_c;
    forever begin
      @(negedge clk);
      if (mon_on && busy && !busy_prev) begin
        mon_busy = 1'b1;
        start_c  = cyc;
        chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else begin
          e.frame = '0; e.nbits = 10; e.start_cyc = -1; e.b2b = 1'b0;
        end
        if (e.start_cyc >= 0) chk("start_latency", start_c, e.start_cyc);
        if (e.b2b) chk("b2b_gap", start_c - last_done_cyc, 1);
        cap      = '0;
        hs_bad   = 1'b0;
        sclk_bad = 1'b0;
        for (int c = 0; c <= e.nbits * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (c < e.nbits * CPB) begin
            if (c % CPB == CPB / 2) cap[c / CPB] = serial;
            if (ready || !busy || done) hs_bad = 1'b1;
`ifdef USRT_SCLK_EN
            if (sclk !== ((c % CPB) >= CPB / 2)) sclk_bad = 1'b1;
`endif
          end else begin
            chk("done_at_end", done, 1);
            chk("ready_at_end", ready, 1);
            chk("line_idle_at_end", serial, 1);
            last_done_cyc = cyc;
          end
        end
        chk("frame", cap, e.frame);
        chk("handshake_in_frame", hs_bad, 0);
`ifdef USRT_SCLK_EN
        chk("sclk_shape", sclk_bad, 0);
`endif
        busy_prev = 1'b0;
        mon_busy  = 1'b0;
      end else begin
        busy_prev = busy;
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    bit   seen;
    logic [7:0] d;
    logic [1:0] m;

    repeat (3) @(negedge clk);
    chk("rst_serial", serial, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef USRT_SCLK_EN
    chk("rst_sclk", sclk, 1);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_serial", serial, 1);
    chk("idle_ready", ready, 1);
    mon_on = 1'b1;

    // Fixed frames: even/odd parity and both no-parity encodings.
    send(8'h35, 2'b01, 11'b10001101010, 11); wait_drain();
    send(8'h34, 2'b10, 11'b10001101000, 11); wait_drain();
    send(8'h34, 2'b01, 11'b11001101000, 11); wait_drain();
    send(8'hA5, 2'b00, 11'b01101001010, 10); wait_drain();
    send(8'hA5, 2'b11, 11'b01101001010, 10); wait_drain();

    // Start held high across a frame, with inputs changing mid-frame.
    tx_start    = 1'b1;
    data        = 8'h5A;
    par         = 2'b01;
    e           = model(8'h5A, 2'b01);
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
    repeat (20) @(negedge clk);
    data  = 8'hFF;
    par   = 2'b10;
    e     = model(8'hFF, 2'b10);
    e.b2b = 1'b1;
    sb_q.push_back(e);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(n < 200), 1);
    @(negedge clk);
    tx_start = 1'b0;
    wait_drain();

    // Random bytes and modes.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      m = 2'($urandom);
      e = model(d, m);
      send(d, m, e.frame, e.nbits);
    end
    wait_drain();

    // Asynchronous reset during data bit 3 aborts the frame.
    mon_on   = 1'b0;
    tx_start = 1'b1;
    data     = 8'h96;
    par      = 2'b01;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_bit3", serial, 0);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_serial", serial, 1);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy || !serial) seen = 1'b1;
    end
    chk("quiet_after_abort", seen, 0);
`ifdef USRT_SCLK_EN
    chk("sclk_idle", sclk, 1);
`endif
    mon_on = 1'b1;
    e = model(8'h96, 2'b01);
    send(8'h96, 2'b01, e.frame, e.nbits);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
